// File: rtl/gpu_mem_arbiter_if.sv
// gpu_mem_arbiter_if: requester-side and RAM-side signal bundle of gpu_mem_arbiter.
// The slave view belongs to the arbiter, the master view to whatever surrounds it.
interface gpu_mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 32
);
    logic [NUM_CONSUMERS-1:0]            consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]            consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]            consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_WIDTH-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_WIDTH-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]            consumer_write_ready;
    logic [NUM_CHANNELS-1:0]             mem_read_valid;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]             mem_read_ready;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]             mem_write_valid;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0]  mem_write_address;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]             mem_write_ready;
    logic                                busy;

    modport master (
        output consumer_read_valid, consumer_read_address, consumer_write_valid,
               consumer_write_address, consumer_write_data, mem_read_ready, mem_read_data,
               mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready, mem_read_valid,
               mem_read_address, mem_write_valid, mem_write_address, mem_write_data, busy
    );
    modport slave (
        input  consumer_read_valid, consumer_read_address, consumer_write_valid,
               consumer_write_address, consumer_write_data, mem_read_ready, mem_read_data,
               mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready, mem_read_valid,
               mem_read_address, mem_write_valid, mem_write_address, mem_write_data, busy
    );
endinterface

// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: round-robin sharing of the data-RAM channels between GPU load/store requesters.
module gpu_mem_arbiter #(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 32
) (
    input logic clk,
    input logic rst,
    gpu_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_CONSUMERS);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t state [NUM_CHANNELS];
    state_t state_next [NUM_CHANNELS];
    logic [IW-1:0] owner [NUM_CHANNELS];
    logic [IW-1:0] grant_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] grant, grant_rd, op_rd, rd_en, wr_en;
    logic [NUM_CONSUMERS-1:0] owned, taken, rd_ready, wr_ready;
    logic [IW-1:0] rr_ptr, rr_next, j;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0] addr;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] wdata;
    logic [NUM_CONSUMERS*DATA_WIDTH-1:0] rdata;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_CONSUMERS);
    endfunction

    // Channels claim in index order; taken keeps a requester from being granted twice per cycle.
    always_comb begin
        taken = '0;
        rr_next = rr_ptr;
        j = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_next[c] = state[c];
            grant[c] = 1'b0;
            grant_rd[c] = 1'b0;
            grant_idx[c] = '0;
            if (state[c] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    j = wrap(int'(rr_ptr) + k);
                    if (!grant[c] && !owned[j] && !taken[j] &&
                        (bus.consumer_read_valid[j] || bus.consumer_write_valid[j])) begin
                        grant[c] = 1'b1;
                        grant_idx[c] = j;
                        grant_rd[c] = bus.consumer_read_valid[j];
                    end
                end
                if (grant[c]) begin
                    taken[grant_idx[c]] = 1'b1;
                    rr_next = wrap(int'(grant_idx[c]) + 1);
                    state_next[c] = grant_rd[c] ? READ_WAIT : WRITE_WAIT;
                end
            end
            else if (state[c] == READ_WAIT && bus.mem_read_ready[c]) state_next[c] = RELAY;
            else if (state[c] == WRITE_WAIT && bus.mem_write_ready[c]) state_next[c] = RELAY;
            else if (state[c] == RELAY && !(op_rd[c] ? bus.consumer_read_valid[owner[c]]
                                                     : bus.consumer_write_valid[owner[c]]))
                state_next[c] = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                owner[c] <= '0;
            end
            {op_rd, rd_en, wr_en, addr, wdata, rdata, owned, rd_ready, wr_ready, rr_ptr} <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= state_next[c];
                if (grant[c]) begin
                    owner[c] <= grant_idx[c];
                    op_rd[c] <= grant_rd[c];
                    owned[grant_idx[c]] <= 1'b1;
                    rd_en[c] <= grant_rd[c];
                    wr_en[c] <= !grant_rd[c];
                    addr[c*ADDR_WIDTH +: ADDR_WIDTH] <= grant_rd[c]
                        ? bus.consumer_read_address[grant_idx[c]*ADDR_WIDTH +: ADDR_WIDTH]
                        : bus.consumer_write_address[grant_idx[c]*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata[c*DATA_WIDTH +: DATA_WIDTH] <= bus.consumer_write_data[grant_idx[c]*DATA_WIDTH +: DATA_WIDTH];
                end
                if (state[c] == READ_WAIT && bus.mem_read_ready[c]) begin
                    rd_en[c] <= 1'b0;
                    rd_ready[owner[c]] <= 1'b1;
                    rdata[owner[c]*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_read_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
                if (state[c] == WRITE_WAIT && bus.mem_write_ready[c]) begin
                    wr_en[c] <= 1'b0;
                    wr_ready[owner[c]] <= 1'b1;
                end
                // Release: read data returns to zero together with ready.
                if (state[c] == RELAY && state_next[c] == IDLE) begin
                    owned[owner[c]] <= 1'b0;
                    rd_ready[owner[c]] <= 1'b0;
                    wr_ready[owner[c]] <= 1'b0;
                    rdata[owner[c]*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
            end
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) bus.busy = bus.busy | (state[c] != IDLE);
    end

    assign bus.mem_read_valid       = rd_en;
    assign bus.mem_write_valid      = wr_en;
    assign bus.mem_read_address     = addr;
    assign bus.mem_write_address    = addr;
    assign bus.mem_write_data       = wdata;
    assign bus.consumer_read_ready  = rd_ready;
    assign bus.consumer_write_ready = wr_ready;
    assign bus.consumer_read_data   = rdata;
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter: directed and randomized checks of gpu_mem_arbiter against a RAM model
// and a shadow-memory reference of what every read must return.
module tb_gpu_mem_arbiter;
    localparam int NC = 8, NCH = 4, AW = 16, DW = 32, M = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    gpu_mem_arbiter_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    gpu_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] ram [0:65535];
    bit ram_wr [0:65535];
    logic [DW-1:0] shadow [logic [AW-1:0]];
    int done_at [NC];
    logic [7:0] v1;
    logic [63:0] a1;
    logic [DW-1:0] d1;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {a, a} ^ 32'h0010_0010;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic int first_wr(input logic [NCH-1:0] pend);
        for (int c = 0; c < NCH; c++) if (pend[c]) return c;
        return -1;
    endfunction

    // RAM: reads answer one cycle after valid; writes acknowledged one per cycle, lowest channel first.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_read_ready <= '0;
            bus.mem_write_ready <= '0;
            bus.mem_read_data <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bus.mem_read_ready[c] <= bus.mem_read_valid[c] && !bus.mem_read_ready[c];
                if (bus.mem_read_valid[c] && !bus.mem_read_ready[c])
                    bus.mem_read_data[c*DW +: DW] <= ram_wr[bus.mem_read_address[c*AW +: AW]]
                        ? ram[bus.mem_read_address[c*AW +: AW]] : init_word(bus.mem_read_address[c*AW +: AW]);
                bus.mem_write_ready[c] <= c == first_wr(bus.mem_write_valid & ~bus.mem_write_ready);
                if (c == first_wr(bus.mem_write_valid & ~bus.mem_write_ready)) begin
                    ram[bus.mem_write_address[c*AW +: AW]] <= bus.mem_write_data[c*DW +: DW];
                    ram_wr[bus.mem_write_address[c*AW +: AW]] <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.consumer_read_valid[i] = rd;
        bus.consumer_write_valid[i] = wr;
        bus.consumer_read_address[i*AW +: AW] = a;
        bus.consumer_write_address[i*AW +: AW] = a;
        bus.consumer_write_data[i*DW +: DW] = d;
        if (wr) shadow[a] = d;
    endtask

    // One transaction: waits for ready, checks hold while valid stays high, then release.
    task automatic do_op(input string tag, input int i, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int exp_lat);
        logic [DW-1:0] exp_d;
        int lat;
        exp_d = rd ? model_rd(a) : '0;
        drive(i, rd, !rd, a, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                v1 = {bus.mem_write_valid, bus.mem_read_valid};
                a1 = rd ? bus.mem_read_address : bus.mem_write_address;
                d1 = bus.mem_write_data[DW-1:0];
            end
        end while (!(rd ? bus.consumer_read_ready[i] : bus.consumer_write_ready[i]) && lat < 60);
        check({tag, "_done"}, rd ? bus.consumer_read_ready[i] : bus.consumer_write_ready[i], 1);
        if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, bus.consumer_read_data[i*DW +: DW], exp_d);
        @(negedge clk);
        check({tag, "_hold"}, {bus.consumer_read_ready[i], bus.consumer_write_ready[i]}, rd ? 2'b10 : 2'b01);
        check({tag, "_hold_data"}, bus.consumer_read_data[i*DW +: DW], exp_d);
        drive(i, 0, 0, a, d);
        @(negedge clk);
        check({tag, "_release"}, {bus.consumer_read_ready[i], bus.consumer_write_ready[i],
                                  bus.consumer_read_data[i*DW +: DW]}, 0);
    endtask

    // Serve every requester whose valid is up; records the completion cycle of each.
    task automatic collect(input bit rd);
        for (int i = 0; i < NC; i++) done_at[i] = -1;
        for (int cyc = 1; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                v1 = {bus.mem_write_valid, bus.mem_read_valid};
                a1 = rd ? bus.mem_read_address : bus.mem_write_address;
            end
            for (int i = 0; i < NC; i++) begin
                if ((rd ? bus.consumer_read_valid[i] : bus.consumer_write_valid[i]) &&
                    (rd ? bus.consumer_read_ready[i] : bus.consumer_write_ready[i])) begin
                    done_at[i] = cyc;
                    if (rd) check("collect_rd", bus.consumer_read_data[i*DW +: DW],
                                  model_rd(bus.consumer_read_address[i*AW +: AW]));
                    drive(i, 0, 0, bus.consumer_read_address[i*AW +: AW], bus.consumer_write_data[i*DW +: DW]);
                end
            end
        end
    endtask

    bit act [NC];
    bit rdop [NC];
    int gap [NC], age [NC], cnt [NC];
    logic [AW-1:0] ra [NC];

    initial begin
        logic [NC-1:0] seen;
        logic [DW-1:0] zero_acc;
        int lat, total;
        bus.consumer_read_valid = '0;
        bus.consumer_write_valid = '0;
        bus.consumer_read_address = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data = '0;
        #12;
        check("reset_ctrl", {bus.busy, bus.mem_read_valid, bus.mem_write_valid,
                             bus.consumer_read_ready, bus.consumer_write_ready}, 0);
        check("reset_data", |{bus.consumer_read_data, bus.mem_read_address, bus.mem_write_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op("rd3", 3, 1, 16'h0010, 32'h0, 3);
        check("rd3_grant", v1, 8'h01);
        check("rd3_addr", a1[AW-1:0], 16'h0010);
        check("rd3_value", init_word(16'h0010), 32'hDEADBEEF);
        check("idle_busy", bus.busy, 0);

        do_op("wr5", 5, 0, 16'h0020, 32'h12345678, 3);
        check("wr5_grant", v1, 8'h10);
        check("wr5_addr", a1[AW-1:0], 16'h0020);
        check("wr5_wdata", d1, 32'h12345678);
        do_op("rb5", 5, 1, 16'h0020, 32'h0, 3);

        drive(1, 1, 0, 16'h0040, 32'h0);
        @(negedge clk);
        check("rst_pre", bus.mem_read_valid, 4'b0001);
        #2 rst = 1'b1;
        #1 check("rst_async", {bus.busy, bus.mem_read_valid, bus.mem_write_valid,
                               bus.consumer_read_ready, bus.consumer_write_ready}, 0);
        drive(1, 0, 0, 16'h0040, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.consumer_read_ready;
        end
        check("rst_no_ready", seen, 0);

        for (int i = 0; i < NC; i++) drive(i, 1, 0, 16'h0100 + AW'(i), 32'h0);
        collect(1);
        check("all8_grant", v1, 8'h0F);
        check("all8_addr", a1, 64'h0103_0102_0101_0100);
        for (int i = 0; i < NC; i++) check("all8_time", done_at[i], i < 4 ? 3 : 7);

        for (int i = 0; i < 4; i++) drive(i, 0, 1, 16'h0200 + AW'(i), $urandom);
        collect(0);
        check("wr4_grant", v1, 8'hF0);
        check("wr4_addr", a1, 64'h0203_0202_0201_0200);
        for (int i = 0; i < 4; i++) check("wr4_order", done_at[i], 3 + i);
        for (int i = 4; i < NC; i++) do_op("wr4_rb", i, 1, 16'h0200 + AW'(i - 4), 32'h0, -1);

        drive(2, 1, 1, 16'h0300, 32'hCAFEF00D);
        @(negedge clk);
        check("dual_first", {bus.mem_write_valid, bus.mem_read_valid}, 8'h01);
        lat = 1;
        while (!bus.consumer_read_ready[2] && lat < 40) begin @(negedge clk); lat++; end
        check("dual_rd_lat", lat, 3);
        check("dual_rd_data", bus.consumer_read_data[2*DW +: DW], init_word(16'h0300));
        bus.consumer_read_valid[2] = 1'b0;
        lat = 0;
        while (!bus.consumer_write_ready[2] && lat < 40) begin @(negedge clk); lat++; end
        check("dual_wr_lat", lat, 4);
        bus.consumer_write_valid[2] = 1'b0;
        @(negedge clk);
        do_op("dual_rb", 2, 1, 16'h0300, 32'h0, 3);

        total = 0;
        for (int i = 0; i < NC; i++) begin act[i] = 0; gap[i] = 0; cnt[i] = 0; age[i] = 0; end
        for (int cyc = 0; cyc < 4000 && total < NC * M; cyc++) begin
            @(negedge clk);
            zero_acc = '0;
            for (int i = 0; i < NC; i++) begin
                if (!bus.consumer_read_ready[i]) zero_acc |= bus.consumer_read_data[i*DW +: DW];
                if (act[i]) begin
                    age[i]++;
                    if (rdop[i] ? bus.consumer_read_ready[i] : bus.consumer_write_ready[i]) begin
                        if (rdop[i]) check("rand_rd", bus.consumer_read_data[i*DW +: DW], model_rd(ra[i]));
                        drive(i, 0, 0, ra[i], 32'h0);
                        act[i] = 0; cnt[i]++; total++; gap[i] = $urandom_range(1, 3);
                    end else if (age[i] > 40) begin
                        check("rand_lat", age[i], 40);
                        drive(i, 0, 0, ra[i], 32'h0);
                        act[i] = 0; cnt[i]++; total++; gap[i] = 3;
                    end
                end else if (gap[i] > 0) gap[i]--;
                else if (cnt[i] < M) begin
                    act[i] = 1; age[i] = 0;
                    rdop[i] = 1'($urandom_range(0, 1));
                    ra[i] = {4'(i + 8), 12'($urandom)};
                    drive(i, rdop[i], !rdop[i], ra[i], $urandom);
                end
            end
            check("rand_zero", zero_acc, 0);
        end
        check("rand_count", total, NC * M);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
